// File: rtl/fractal_sync_1d_req_ctrl.sv
// Per-port barrier request controller for a fractal sync node: classifies child
// requests, pulses the 1D RF check, and answers, forwards upward or absorbs.
module fractal_sync_1d_req_ctrl #(
    parameter int LEVEL_WIDTH = 2,
    parameter int ID_WIDTH    = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [1:0]                        req_valid_i,
    output logic [1:0]                        req_ready_o,
    input  logic [1:0][LEVEL_WIDTH-1:0]       req_level_i,
    input  logic [1:0][ID_WIDTH-1:0]          req_id_i,
    output logic [1:0][LEVEL_WIDTH-1:0]       rf_level_o,
    output logic [1:0][ID_WIDTH-1:0]          rf_id_o,
    output logic [1:0]                        rf_check_local_o,
    output logic [1:0]                        rf_check_remote_o,
    input  logic [1:0]                        rf_present_local_i,
    input  logic [1:0]                        rf_present_remote_i,
    input  logic [1:0]                        rf_id_err_i,
    input  logic [1:0]                        rf_sig_err_i,
    input  logic                              rf_bypass_local_i,
    input  logic                              rf_bypass_remote_i,
    output logic [1:0]                        rsp_valid_o,
    input  logic [1:0]                        rsp_ready_i,
    output logic [1:0][1:0]                   rsp_type_o,
    output logic [1:0][ID_WIDTH-1:0]          rsp_id_o,
    output logic                              up_valid_o,
    input  logic                              up_ready_i,
    output logic [LEVEL_WIDTH-1:0]            up_level_o,
    output logic [ID_WIDTH-1:0]               up_id_o,
    output logic                              up_src_o
);

    localparam int N_PORTS = 2;

    localparam logic [1:0] RSP_ERR_LVL = 2'b00;
    localparam logic [1:0] RSP_DONE    = 2'b01;
    localparam logic [1:0] RSP_ERR_ID  = 2'b10;
    localparam logic [1:0] RSP_ERR_SIG = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RSP   = 2'd2,
        FWD   = 2'd3
    } state_t;

    logic [N_PORTS-1:0]                  fwd;
    logic [N_PORTS-1:0][LEVEL_WIDTH-1:0] lvl_all;
    logic [N_PORTS-1:0][ID_WIDTH-1:0]    id_all;
    logic                                grant;
    logic                                grant_q;
    logic                                ptr;
    logic                                lock;
    logic                                rr_pick;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        localparam bit IS_P0 = (p == 0);

        state_t                 state;
        logic [LEVEL_WIDTH-1:0] lvl;
        logic [ID_WIDTH-1:0]    id;
        logic [1:0]             rtype;
        logic                   chk_loc;
        logic                   chk_rem;
        logic                   is_loc;
        logic                   is_rem;

        assign is_loc = (lvl == LEVEL_WIDTH'(1));
        assign is_rem = (lvl > LEVEL_WIDTH'(1));

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state   <= IDLE;
                lvl     <= '0;
                id      <= '0;
                rtype   <= '0;
                chk_loc <= 1'b0;
                chk_rem <= 1'b0;
            end else begin
                chk_loc <= 1'b0;
                chk_rem <= 1'b0;
                case (state)
                    IDLE: begin
                        if (req_valid_i[p]) begin
                            lvl     <= req_level_i[p];
                            id      <= req_id_i[p];
                            chk_loc <= (req_level_i[p] == LEVEL_WIDTH'(1));
                            chk_rem <= (req_level_i[p] > LEVEL_WIDTH'(1));
                            state   <= CHECK;
                        end
                    end
                    CHECK: begin
                        // Bypass credit goes to port 0 only, so a matched pair yields one result.
                        if (lvl == '0) begin
                            rtype <= RSP_ERR_LVL;
                            state <= RSP;
                        end else if (rf_id_err_i[p]) begin
                            rtype <= RSP_ERR_ID;
                            state <= RSP;
                        end else if (rf_sig_err_i[p]) begin
                            rtype <= RSP_ERR_SIG;
                            state <= RSP;
                        end else if (is_loc && (rf_present_local_i[p] ||
                                                (rf_bypass_local_i && IS_P0))) begin
                            rtype <= RSP_DONE;
                            state <= RSP;
                        end else if (is_rem && (rf_present_remote_i[p] ||
                                                (rf_bypass_remote_i && IS_P0))) begin
                            state <= FWD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    RSP: begin
                        if (rsp_ready_i[p]) state <= IDLE;
                    end
                    FWD: begin
                        if (up_ready_i && (grant == 1'(p))) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign req_ready_o[p]       = (state == IDLE) && !rst_i;
        assign rf_level_o[p]        = lvl;
        assign rf_id_o[p]           = id;
        assign rf_check_local_o[p]  = chk_loc;
        assign rf_check_remote_o[p] = chk_rem;
        assign rsp_valid_o[p]       = (state == RSP);
        assign rsp_type_o[p]        = rtype;
        assign rsp_id_o[p]          = id;
        assign fwd[p]               = (state == FWD);
        assign lvl_all[p]           = lvl;
        assign id_all[p]            = id;
    end

    // Grant is frozen while a forward is stalled so the upward payload stays stable.
    assign rr_pick    = fwd[ptr] ? ptr : ~ptr;
    assign grant      = lock ? grant_q : rr_pick;
    assign up_valid_o = |fwd;
    assign up_src_o   = up_valid_o ? grant : 1'b0;
    assign up_level_o = up_valid_o ? (lvl_all[grant] - LEVEL_WIDTH'(1)) : '0;
    assign up_id_o    = up_valid_o ? id_all[grant] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr     <= 1'b0;
            lock    <= 1'b0;
            grant_q <= 1'b0;
        end else begin
            grant_q <= grant;
            if (up_valid_o && up_ready_i) begin
                ptr  <= ~grant;
                lock <= 1'b0;
            end else begin
                lock <= up_valid_o;
            end
        end
    end

endmodule

// File: tb/tb_fractal_sync_1d_req_ctrl.sv
// Scoreboard bench for fractal_sync_1d_req_ctrl: expected responses and upward
// forwards are queued at issue time and matched against DUT handshakes.
module tb_fractal_sync_1d_req_ctrl;

    localparam int LW = 2;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [1:0][LW-1:0] req_level;
    logic [1:0][IW-1:0] req_id;
    logic [1:0][LW-1:0] rf_level;
    logic [1:0][IW-1:0] rf_id;
    logic [1:0]         chk_loc, chk_rem;
    logic [1:0]         pres_loc, pres_rem, id_err, sig_err;
    logic               byp_loc, byp_rem;
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready;
    logic [1:0][1:0]    rsp_type;
    logic [1:0][IW-1:0] rsp_id;
    logic               up_valid, up_ready;
    logic [LW-1:0]      up_level;
    logic [IW-1:0]      up_id;
    logic               up_src;

    fractal_sync_1d_req_ctrl #(.LEVEL_WIDTH(LW), .ID_WIDTH(IW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_level_i(req_level), .req_id_i(req_id),
        .rf_level_o(rf_level), .rf_id_o(rf_id),
        .rf_check_local_o(chk_loc), .rf_check_remote_o(chk_rem),
        .rf_present_local_i(pres_loc), .rf_present_remote_i(pres_rem),
        .rf_id_err_i(id_err), .rf_sig_err_i(sig_err),
        .rf_bypass_local_i(byp_loc), .rf_bypass_remote_i(byp_rem),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_type_o(rsp_type), .rsp_id_o(rsp_id),
        .up_valid_o(up_valid), .up_ready_i(up_ready),
        .up_level_o(up_level), .up_id_o(up_id), .up_src_o(up_src)
    );

    int total = 0;
    int bad   = 0;

    logic [3:0] rsp_q0[$];
    logic [3:0] rsp_q1[$];
    logic [4:0] up_q[$];
    logic       ptr_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one request per selected port, play the RF during the check cycle,
    // and queue what the controller must produce.
    task automatic issue(input logic [1:0] v, input logic [1:0][LW-1:0] lv,
                         input logic [1:0][IW-1:0] id, input logic [1:0] pl,
                         input logic [1:0] pr, input logic [1:0] ie,
                         input logic [1:0] se, input logic bl, input logic br);
        logic [1:0] f;
        f = 2'b00;
        for (int p = 0; p < 2; p++)
            if (v[p]) check($sformatf("rdy_before%0d", p), req_ready[p], 1'b1);
        req_valid = v;
        req_level = lv;
        req_id    = id;
        tick(1);
        req_valid = 2'b00;
        pres_loc = pl; pres_rem = pr; id_err = ie; sig_err = se;
        byp_loc = bl; byp_rem = br;
        for (int p = 0; p < 2; p++) begin
            check($sformatf("chk_loc%0d", p), chk_loc[p], v[p] && (lv[p] == 2'd1));
            check($sformatf("chk_rem%0d", p), chk_rem[p], v[p] && (lv[p] >= 2'd2));
            if (v[p]) begin
                check($sformatf("rf_level%0d", p), rf_level[p], lv[p]);
                check($sformatf("rf_id%0d", p), rf_id[p], id[p]);
                if (lv[p] == 2'd0 || ie[p] || se[p] ||
                    (lv[p] == 2'd1 && (pl[p] || (bl && p == 0)))) begin
                    logic [1:0] t;
                    if (lv[p] == 2'd0)  t = 2'b00;
                    else if (ie[p])     t = 2'b10;
                    else if (se[p])     t = 2'b11;
                    else                t = 2'b01;
                    if (p == 0) rsp_q0.push_back({t, id[p]});
                    else        rsp_q1.push_back({t, id[p]});
                end else if (lv[p] >= 2'd2 && (pr[p] || (br && p == 0))) begin
                    f[p] = 1'b1;
                end
            end
        end
        if (f == 2'b11) begin
            up_q.push_back({lv[ptr_m] - 2'd1, id[ptr_m], ptr_m});
            up_q.push_back({lv[~ptr_m] - 2'd1, id[~ptr_m], ~ptr_m});
        end else if (f != 2'b00) begin
            up_q.push_back({lv[f[1]] - 2'd1, id[f[1]], f[1]});
            ptr_m = ~f[1];
        end
        tick(1);
        pres_loc = '0; pres_rem = '0; id_err = '0; sig_err = '0;
        byp_loc = 1'b0; byp_rem = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                if (rsp_valid[p] && rsp_ready[p]) begin
                    if ((p == 0 ? rsp_q0.size() : rsp_q1.size()) == 0) begin
                        check($sformatf("rsp_unexp%0d", p), rsp_valid[p], 1'b0);
                    end else begin
                        logic [3:0] e;
                        e = (p == 0) ? rsp_q0.pop_front() : rsp_q1.pop_front();
                        check($sformatf("rsp_type%0d", p), rsp_type[p], e[3:2]);
                        check($sformatf("rsp_id%0d", p), rsp_id[p], e[1:0]);
                    end
                end
            end
            if (up_valid && up_ready) begin
                if (up_q.size() == 0) begin
                    check("up_unexp", up_valid, 1'b0);
                end else begin
                    logic [4:0] e;
                    e = up_q.pop_front();
                    check("up_level", up_level, e[4:3]);
                    check("up_id", up_id, e[2:1]);
                    check("up_src", up_src, e[0]);
                end
            end
        end
    end

    initial begin
        req_valid = '0; req_level = '0; req_id = '0;
        pres_loc = '0; pres_rem = '0; id_err = '0; sig_err = '0;
        byp_loc = 1'b0; byp_rem = 1'b0;
        rsp_ready = 2'b11; up_ready = 1'b1;

        tick(2);
        check("rst_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_up_valid", up_valid, 1'b0);
        check("rst_checks", {chk_loc, chk_rem}, 4'b0);
        check("rst_data", {rf_level, rf_id, rsp_type, up_level, up_id}, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", req_ready, 2'b11);
        tick(1);

        // local pair: first arrival absorbed, partner completes
        issue(2'b01, {2'd0, 2'd1}, {2'd0, 2'd3}, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        check("absorb_no_rsp", rsp_valid[0], 1'b0);
        check("absorb_ready", req_ready[0], 1'b1);
        tick(1);
        issue(2'b10, {2'd1, 2'd0}, {2'd3, 2'd0}, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        check("done_valid_t2", rsp_valid[1], 1'b1);
        tick(3);

        // remote bypass: only port 0 forwards
        issue(2'b11, {2'd3, 2'd3}, {2'd1, 2'd1}, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        check("byp_up_valid", up_valid, 1'b1);
        check("byp_no_rsp", rsp_valid, 2'b00);
        tick(3);

        // errors: level 0 on port 0, id_err over sig_err on port 1
        issue(2'b11, {2'd2, 2'd0}, {2'd2, 2'd1}, 2'b00, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0);
        tick(3);

        // local bypass credited to port 0 only
        issue(2'b11, {2'd1, 2'd1}, {2'd2, 2'd2}, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        tick(3);

        // response backpressure
        rsp_ready = 2'b10;
        issue(2'b01, {2'd0, 2'd1}, {2'd0, 2'd2}, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid[0], 1'b1);
            check("bp_type", rsp_type[0], 2'b11);
            check("bp_id", rsp_id[0], 2'd2);
            check("bp_ready", req_ready[0], 1'b0);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        tick(2);
        check("bp_ready_back", req_ready[0], 1'b1);

        // arbitration: steer pointer to 0, pair, then steer to 1, pair
        issue(2'b10, {2'd2, 2'd0}, {2'd1, 2'd0}, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
        tick(3);
        issue(2'b11, {2'd2, 2'd3}, {2'd1, 2'd2}, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
        tick(4);
        issue(2'b01, {2'd0, 2'd2}, {2'd0, 2'd3}, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        tick(3);
        issue(2'b11, {2'd3, 2'd2}, {2'd3, 2'd0}, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
        tick(4);

        // reset while port 0 sits stalled in FWD
        up_ready = 1'b0;
        issue(2'b01, {2'd0, 2'd3}, {2'd0, 2'd1}, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        tick(2);
        check("stall_up_valid", up_valid, 1'b1);
        check("stall_up_level", up_level, 2'd2);
        check("stall_ready", req_ready[0], 1'b0);
        rst = 1'b1;
        tick(1);
        check("mid_rst_valids", {rsp_valid, up_valid}, 3'b000);
        check("mid_rst_ready", req_ready, 2'b00);
        check("mid_rst_data", {rf_level, up_level, up_id}, 0);
        up_q.delete();
        ptr_m = 1'b0;
        up_ready = 1'b1;
        rst = 1'b0;
        #1;
        check("post_rst_ready", req_ready, 2'b11);
        tick(5);
        check("no_stale_fwd", up_valid, 1'b0);

        issue(2'b01, {2'd0, 2'd1}, {2'd0, 2'd1}, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

        for (int i = 0; i < 50; i++) begin
            if (rsp_q0.size() == 0 && rsp_q1.size() == 0 && up_q.size() == 0) break;
            tick(1);
        end
        tick(2);
        check("drain_rsp0", rsp_q0.size(), 0);
        check("drain_rsp1", rsp_q1.size(), 0);
        check("drain_up", up_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
